// File: rtl/fib_seq_gen_if.sv
// Handshake/result bundle for fib_seq_gen: job request in, status, result and term stream out.
interface fib_seq_gen_if #(
    parameter int WIDTH = 8,
    parameter int N_W   = 6
);
    logic             start;
    logic [N_W-1:0]   n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             term_valid;
    logic [WIDTH-1:0] term;

    modport master (
        output start, n,
        input  busy, done, result, overflow, term_valid, term
    );

    modport slave (
        input  start, n,
        output busy, done, result, overflow, term_valid, term
    );
endinterface

// File: rtl/fib_seq_gen.sv
// Iterative Fibonacci generator: computes F(n) over n+1 RUN cycles, streaming each term.
// Optional build macro FIB_SATURATE_EN: overflowing terms clamp to all-ones instead of wrapping.
module fib_seq_gen #(
    parameter int WIDTH = 8,
    parameter int N_W   = 6
) (
    input  logic          clk,
    input  logic          rst,
    fib_seq_gen_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a, b;
    logic [N_W-1:0]   cnt;
    logic             a_tag, b_tag;
    logic             busy_q, done_q, overflow_q, term_valid_q;
    logic [WIDTH-1:0] result_q, term_q;

    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] b_next;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        carry = sum[WIDTH];
`ifdef FIB_SATURATE_EN
        // Once b carries a tag every later term is derived from a saturated value.
        b_next = (carry || b_tag) ? '1 : sum[WIDTH-1:0];
`else
        b_next = sum[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a            <= '0;
            b            <= '0;
            cnt          <= '0;
            a_tag        <= 1'b0;
            b_tag        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            term_valid_q <= 1'b0;
            result_q     <= '0;
            term_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a            <= '0;
                        b            <= WIDTH'(1);
                        cnt          <= bus.n;
                        a_tag        <= 1'b0;
                        b_tag        <= 1'b0;
                        busy_q       <= 1'b1;
                        term_valid_q <= 1'b1;
                        term_q       <= '0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        a      <= b;
                        b      <= b_next;
                        cnt    <= cnt - 1'b1;
                        a_tag  <= b_tag;
                        b_tag  <= b_tag | carry;
                        // term mirrors the new a so it tracks a without a comb path
                        term_q <= b;
                    end else begin
                        result_q     <= a;
                        overflow_q   <= a_tag;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        term_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.overflow   = overflow_q;
    assign bus.term_valid = term_valid_q;
    assign bus.term       = term_q;
endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: driver pushes expected results, monitor checks done and term stream.
module tb_fib_seq_gen;
    localparam int W  = 8;
    localparam int NW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fib_seq_gen_if #(.WIDTH(W), .N_W(NW)) bus ();

    fib_seq_gen #(.WIDTH(W), .N_W(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int           n;
        longint       done_cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     job_q[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: exact Fibonacci value, then wrap or clamp to W bits.
    function automatic logic [W:0] model(input int i);
        longint unsigned f0 = 0, f1 = 1, t;
        logic ovf;
        logic [W-1:0] v;
        for (int k = 0; k < i; k++) begin
            t  = f0 + f1;
            f0 = f1;
            f1 = t;
        end
        ovf = (f0 >= (64'd1 << W));
`ifdef FIB_SATURATE_EN
        v = ovf ? {W{1'b1}} : W'(f0);
`else
        v = W'(f0 % (64'd1 << W));
`endif
        return {ovf, v};
    endfunction

    // Monitor
    bit in_job = 0;
    int cur_n = 0;
    int idx = 0;
    int last_len = 0;
    always @(negedge clk) begin
        logic [W:0] m;
        if (rst) begin
            in_job = 0;
            idx = 0;
        end else begin
            if (bus.term_valid) begin
                if (!in_job) begin
                    if (job_q.size() == 0) begin
                        chk("term_job_missing", 1, 0);
                        cur_n = 0;
                    end else begin
                        cur_n = job_q.pop_front();
                    end
                    in_job = 1;
                    idx = 0;
                end
                m = model(idx);
                chk($sformatf("term[n=%0d,i=%0d]", cur_n, idx), longint'(bus.term), longint'(m[W-1:0]));
                idx++;
            end else if (in_job) begin
                in_job = 0;
                last_len = idx;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("result[n=%0d]", e.n), longint'(bus.result), longint'(e.res));
                    chk($sformatf("overflow[n=%0d]", e.n), longint'(bus.overflow), longint'(e.ovf));
                    chk($sformatf("latency[n=%0d]", e.n), cyc, e.done_cyc);
                    chk($sformatf("busy_len[n=%0d]", e.n), longint'(last_len), longint'(e.n + 1));
                end
            end
        end
    end

    // Drive start for one sampling edge; caller is at a negedge with the DUT idle.
    task automatic issue(input int nv, input bit expect_done);
        logic [W:0] m;
        m = model(nv);
        bus.start = 1'b1;
        bus.n     = NW'(nv);
        job_q.push_back(nv);
        if (expect_done)
            exp_q.push_back('{res: m[W-1:0], ovf: m[W], n: nv, done_cyc: cyc + 2 + nv});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.done && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("done_timeout", 1, 0);
    endtask

    initial begin
        int dir_n[5] = '{12, 0, 1, 13, 14};
        bus.start = 1'b0;
        bus.n     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_term_valid", longint'(bus.term_valid), 0);
        chk("rst_result", longint'(bus.result), 0);
        chk("rst_overflow", longint'(bus.overflow), 0);
        chk("rst_term", longint'(bus.term), 0);

        foreach (dir_n[i]) begin
            issue(dir_n[i], 1);
            wait_drain();
        end

        // Start pulsed mid-job must be dropped.
        issue(12, 1);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.n     = NW'(3);
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);

        // Start presented in the done cycle must be accepted.
        issue(12, 1);
        wait_done();
        issue(3, 1);
        wait_drain();

        // Reset five cycles into a job aborts it silently.
        issue(12, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", longint'(bus.busy), 0);
        chk("abort_done", longint'(bus.done), 0);
        chk("abort_result", longint'(bus.result), 0);
        chk("abort_term_valid", longint'(bus.term_valid), 0);
        repeat (20) @(negedge clk);
        issue(5, 1);
        wait_drain();

        for (int j = 0; j < 20; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(int'($urandom_range(0, 30)), 1);
            wait_drain();
        end

        repeat (10) @(negedge clk);
        chk("exp_q_empty", longint'(exp_q.size()), 0);
        chk("job_q_empty", longint'(job_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
